// File: rtl/rom_seq_pkg.sv
// Shared types and default widths for the sequential ROM burst reader.
package rom_seq_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;
  localparam int SETTLE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_OUTPUT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/rom_seq_reader_if.sv
// Burst command, ROM bus and output stream of rom_seq_reader.
// ROM_SEQ_PARITY_EN adds the out_parity signal.
interface rom_seq_reader_if
  import rom_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] length;
  logic              abort;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_sel;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
`ifdef ROM_SEQ_PARITY_EN
  logic              out_parity;

  modport slave (
    input  start, start_addr, length, abort, rom_data, out_ready,
    output rom_addr, rom_sel, out_data, out_valid, busy, done, out_parity
  );
  modport master (
    output start, start_addr, length, abort, rom_data, out_ready,
    input  rom_addr, rom_sel, out_data, out_valid, busy, done, out_parity
  );
`else
  modport slave (
    input  start, start_addr, length, abort, rom_data, out_ready,
    output rom_addr, rom_sel, out_data, out_valid, busy, done
  );
  modport master (
    output start, start_addr, length, abort, rom_data, out_ready,
    input  rom_addr, rom_sel, out_data, out_valid, busy, done
  );
`endif

endinterface

// File: rtl/rom_seq_addr_gen.sv
// Address and remaining-word counter for a ROM burst; last_o flags the
// final word. A zero length loads a full 2^ADDR_W word burst.
module rom_seq_addr_gen
  import rom_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] length_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;

  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    if (load_i) begin
      addr_d   = start_addr_i;
      remain_d = (length_i == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, length_i};
    end else if (step_i) begin
      // Address wraps silently through natural overflow.
      addr_d   = addr_q + ADDR_W'(1);
      remain_d = remain_q - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (remain_q == (ADDR_W+1)'(1));

endmodule

// File: rtl/rom_seq_reader.sv
// Reads a burst of consecutive ROM words, holding the address for
// SETTLE_CYC cycles before each capture. ROM_SEQ_PARITY_EN adds out_parity.
module rom_seq_reader
  import rom_seq_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  rom_seq_reader_if.slave  bus
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);

  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [DATA_W-1:0]   out_data_q;
  logic                load, step, capture, last;
  logic [ADDR_W-1:0]   rom_addr;

  rom_seq_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .step_i       (step),
    .start_addr_i (bus.start_addr),
    .length_i     (bus.length),
    .addr_o       (rom_addr),
    .last_o       (last)
  );

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    load     = 1'b0;
    step     = 1'b0;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          load     = 1'b1;
          settle_d = '0;
          state_d  = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (bus.abort) begin
          settle_d = '0;
          state_d  = ST_IDLE;
        end else if (settle_q == SETTLE_LAST) begin
          capture  = 1'b1;
          settle_d = '0;
          state_d  = ST_OUTPUT;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      ST_OUTPUT: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.out_ready) begin
          step    = !last;
          state_d = last ? ST_DONE : ST_SELECT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      if (capture) out_data_q <= bus.rom_data;
    end
  end

`ifdef ROM_SEQ_PARITY_EN
  logic out_parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          out_parity_q <= 1'b0;
    else if (capture) out_parity_q <= ^bus.rom_data;
  end

  assign bus.out_parity = out_parity_q;
`endif

  // Status outputs decode straight from the registered state.
  assign bus.rom_addr  = rom_addr;
  assign bus.rom_sel   = (state_q == ST_SELECT) || (state_q == ST_OUTPUT);
  assign bus.out_valid = (state_q == ST_OUTPUT);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_rom_seq_reader.sv
// Scoreboard bench for rom_seq_reader: bursts push expected words, a
// negedge monitor pops and checks them. Define ROM_SEQ_PARITY_EN for parity.
module tb_rom_seq_reader;

  localparam int AW     = 3;
  localparam int DW     = 8;
  localparam int SETTLE = 1;
  localparam int NWORDS = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   n_words = 0;
  int   last_accept = 0;
  int   exp_rise = 0;
  int   ready_mode = 0;
  bit   burst_active = 1'b0;
  bit   mon_prev_valid = 1'b0;
  exp_t exp_q[$];

  rom_seq_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  rom_seq_reader #(.ADDR_W(AW), .DATA_W(DW), .SETTLE_CYC(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_word(input int a);
    case (a % NWORDS)
      0: return 8'h01;
      1: return 8'h03;
      2: return 8'h09;
      3: return 8'h31;
      4: return 8'h71;
      5: return 8'h39;
      6: return 8'h41;
      default: return 8'h81;
    endcase
  endfunction

  assign bus_if.rom_data = bus_if.rom_sel ? rom_word(int'(bus_if.rom_addr)) : '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ready driver: 0 = always ready, 1 = random, 2 = held low.
  initial begin
    bus_if.out_ready = 1'b1;
    forever begin
      tick();
      case (ready_mode)
        0:       bus_if.out_ready = 1'b1;
        1:       bus_if.out_ready = 1'($urandom_range(0, 1));
        default: bus_if.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every presented word is checked against the queue head; a
  // handshake pops it and sets the timing expectations for what follows.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev_valid = 1'b0;
        continue;
      end
      if (bus_if.done) begin
        n_done++;
        check("done_expected", 32'(burst_active && exp_q.size() == 0), 1);
        check("done_cycle", cyc, last_accept);
      end
      if (bus_if.out_valid) begin
        check("word_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          if (!mon_prev_valid) check("valid_rise_cycle", cyc, exp_rise);
          check("out_data", bus_if.out_data, exp_q[0].data);
          check("rom_addr", bus_if.rom_addr, exp_q[0].addr);
`ifdef ROM_SEQ_PARITY_EN
          check("out_parity", bus_if.out_parity, ^exp_q[0].data);
`endif
          if (bus_if.out_ready && !bus_if.abort) begin
            $display("word %0d addr=%0d data=%02h cycle=%0d",
                     n_words, bus_if.rom_addr, bus_if.out_data, cyc);
            void'(exp_q.pop_front());
            n_words++;
            last_accept = cyc + 1;
            exp_rise    = cyc + 1 + SETTLE;
          end
        end
      end
      mon_prev_valid = bus_if.out_valid;
    end
  end

  // Called at posedge+1 with the DUT idle; returns just after the start edge.
  task automatic issue(input logic [AW-1:0] sa, input logic [AW-1:0] len);
    int n;
    exp_t e;
    n = (len == 0) ? NWORDS : int'(len);
    for (int i = 0; i < n; i++) begin
      e.addr = AW'((int'(sa) + i) % NWORDS);
      e.data = rom_word(int'(sa) + i);
      exp_q.push_back(e);
    end
    burst_active = 1'b1;
    exp_rise = cyc + 1 + SETTLE;
    bus_if.start = 1'b1;
    bus_if.start_addr = sa;
    bus_if.length = len;
    $display("burst start_addr=%0d length=%0d words=%0d cycle=%0d", sa, len, n, cyc);
    tick();
    bus_if.start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int exp_done_delta, input int done0);
    int k;
    k = 0;
    while (bus_if.busy && k < 300) begin
      tick();
      k++;
    end
    check({name, "_idle"}, bus_if.busy, 0);
    check({name, "_words_left"}, exp_q.size(), 0);
    check({name, "_done_count"}, n_done - done0, exp_done_delta);
    burst_active = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!bus_if.out_valid && k < 50) begin
      tick();
      k++;
    end
    check({name, "_valid_seen"}, bus_if.out_valid, 1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rom_addr"}, bus_if.rom_addr, 0);
    check({name, "_rom_sel"}, bus_if.rom_sel, 0);
    check({name, "_out_data"}, bus_if.out_data, 0);
    check({name, "_out_valid"}, bus_if.out_valid, 0);
    check({name, "_busy"}, bus_if.busy, 0);
    check({name, "_done"}, bus_if.done, 0);
`ifdef ROM_SEQ_PARITY_EN
    check({name, "_out_parity"}, bus_if.out_parity, 0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [AW-1:0] sa, len;
    bit do_abort;

    bus_if.start = 1'b0;
    bus_if.start_addr = '0;
    bus_if.length = '0;
    bus_if.abort = 1'b0;

    #2;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tick();

    // Three words, ready held high: valid on cycles 2,4,6, done on 7.
    ready_mode = 0;
    d0 = n_done; issue(3'd0, 3'd3); wait_idle("len3", 1, d0);
    d0 = n_done; issue(3'd6, 3'd4); wait_idle("wrap", 1, d0);
    d0 = n_done; issue(3'd2, 3'd0); wait_idle("full", 1, d0);

    // Stall the first word for five cycles.
    ready_mode = 2;
    d0 = n_done; issue(3'd0, 3'd2);
    wait_valid("stall");
    repeat (5) tick();
    check("stall_rom_addr", bus_if.rom_addr, 0);
    check("stall_words_left", exp_q.size(), 2);
    ready_mode = 0;
    wait_idle("stall", 1, d0);

    // Abort in the second SELECT; a start during the burst is ignored.
    d0 = n_done; issue(3'd0, 3'd4);
    tick();
    bus_if.start = 1'b1; bus_if.start_addr = 3'd5; bus_if.length = 3'd1;
    tick();
    bus_if.start = 1'b0;
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    check("abort_rom_sel", bus_if.rom_sel, 0);
    check("abort_busy", bus_if.busy, 0);
    check("abort_out_valid", bus_if.out_valid, 0);
    check("abort_words_left", exp_q.size(), 3);
    exp_q.delete();
    burst_active = 1'b0;
    repeat (4) tick();
    wait_idle("abort", 0, d0);

    // Asynchronous reset while a word is presented.
    ready_mode = 2;
    d0 = n_done; issue(3'd3, 3'd2);
    wait_valid("rst_mid");
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_mid");
    exp_q.delete();
    burst_active = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;
    repeat (5) tick();
    wait_idle("rst_mid", 0, d0);

    // Randomized bursts with random backpressure, ignored starts and aborts.
    for (int it = 0; it < 40; it++) begin
      sa = AW'($urandom_range(0, NWORDS - 1));
      len = AW'($urandom_range(0, NWORDS - 1));
      ready_mode = int'($urandom_range(0, 1));
      do_abort = ($urandom_range(0, 3) == 0);
      d0 = n_done;
      issue(sa, len);
      repeat ($urandom_range(0, 8)) begin
        if (exp_q.size() != 0 && $urandom_range(0, 2) == 0) begin
          bus_if.start = 1'b1;
          bus_if.start_addr = AW'($urandom_range(0, NWORDS - 1));
          bus_if.length = AW'($urandom_range(0, NWORDS - 1));
        end
        tick();
        bus_if.start = 1'b0;
      end
      if (do_abort && exp_q.size() != 0) begin
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;
        check("rand_abort_busy", bus_if.busy, 0);
        exp_q.delete();
        burst_active = 1'b0;
        repeat (2) tick();
        wait_idle("rand_abort", 0, d0);
      end else begin
        wait_idle("rand", 1, d0);
      end
    end

    ready_mode = 0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
